// File: rtl/sri_yantra_pkg.sv
//------------------------------------------------------------------------------
// Module  : sri_yantra_pkg
// Brief   : Shared types and constants for the Bhupura posted write buffer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sri_yantra_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_READ  = 2'd2
    } wb_state_e;

    localparam int WB_DEPTH_DEFAULT = 9;
    localparam int WORD_OFFSET_BITS = 3;

endpackage : sri_yantra_pkg

`default_nettype wire

// File: rtl/bhupura_write_buffer_if.sv
//------------------------------------------------------------------------------
// Module  : bhupura_write_buffer_if
// Brief   : Request/completion bus used on both the cache and memory sides.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface bhupura_write_buffer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    logic                  valid;
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  ready;

    modport master (
        output valid, write, addr, wdata,
        input  rdata, ready
    );

    modport slave (
        input  valid, write, addr, wdata,
        output rdata, ready
    );
endinterface : bhupura_write_buffer_if

`default_nettype wire

// File: rtl/bhupura_wb_match.sv
//------------------------------------------------------------------------------
// Module  : bhupura_wb_match
// Brief   : Combinational youngest-match finder over the circular write buffer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bhupura_wb_match #(
    parameter int DEPTH = 9,
    parameter int TAG_W = 29,
    parameter int PTR_W = 4
) (
    input  wire logic [DEPTH-1:0] i_valid,
    input  wire logic [TAG_W-1:0] i_tag [DEPTH],
    input  wire logic [PTR_W-1:0] i_head,
    input  wire logic [PTR_W-1:0] i_tail,
    input  wire logic [TAG_W-1:0] i_addr_tag,
    output logic                  o_hit,
    output logic [PTR_W-1:0]      o_idx
);

    localparam int DW = PTR_W + 1;

    // Distance of a slot from head: larger distance means a younger entry.
    function automatic logic [DW-1:0] dist_from_head(input logic [DW-1:0] pos,
                                                     input logic [DW-1:0] head);
        if (pos >= head) begin
            return pos - head;
        end
        return pos + DW'(DEPTH) - head;
    endfunction

    logic [DW-1:0]    w_dist [DEPTH];
    logic [DW-1:0]    w_tail_dist;
    logic [DEPTH-1:0] w_cand;

    assign w_tail_dist = dist_from_head({1'b0, i_tail}, {1'b0, i_head});

    // head==tail means empty or full; the valid bits then decide occupancy.
    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_entry
            assign w_dist[i] = dist_from_head(DW'(i), {1'b0, i_head});
            assign w_cand[i] = i_valid[i] && (i_tag[i] == i_addr_tag) &&
                               ((i_head == i_tail) || (w_dist[i] < w_tail_dist));
        end
    endgenerate

    logic          w_hit;
    logic [PTR_W-1:0] w_idx;
    logic [DW-1:0] w_best;

    always_comb begin
        w_hit  = 1'b0;
        w_idx  = '0;
        w_best = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_cand[i] && (!w_hit || (w_dist[i] > w_best))) begin
                w_hit  = 1'b1;
                w_idx  = PTR_W'(i);
                w_best = w_dist[i];
            end
        end
    end

    assign o_hit = w_hit;
    assign o_idx = w_idx;

endmodule : bhupura_wb_match

`default_nettype wire

// File: rtl/bhupura_write_buffer.sv
//------------------------------------------------------------------------------
// Module  : bhupura_write_buffer
// Brief   : Posted write buffer between the cache memory port and main memory,
//           with read forwarding, read-ahead-of-drain and idle-time draining.
//           Optional macro BHUPURA_COALESCE_EN: same-word writes merge in place.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bhupura_write_buffer #(
    parameter int ADDR_WIDTH       = 32,
    parameter int DATA_WIDTH       = 64,
    parameter int DEPTH            = sri_yantra_pkg::WB_DEPTH_DEFAULT,
    parameter int WORD_OFFSET_BITS = sri_yantra_pkg::WORD_OFFSET_BITS
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    bhupura_write_buffer_if.slave           up,
    bhupura_write_buffer_if.master          dn,
    output logic [$clog2(DEPTH+1)-1:0]      wb_count,
    output logic                            wb_empty,
    output logic                            wb_full
);

    import sri_yantra_pkg::*;

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int TAG_W = ADDR_WIDTH - WORD_OFFSET_BITS;

    localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_depth    = CNT_W'(DEPTH);

    wb_state_e             state_q,     state_d;
    logic [PTR_W-1:0]      head_q,      head_d;
    logic [PTR_W-1:0]      tail_q,      tail_d;
    logic [CNT_W-1:0]      count_q,     count_d;
    logic [DEPTH-1:0]      valid_q,     valid_d;
    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_d [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];
    logic                  up_ready_q,  up_ready_d;
    logic [DATA_WIDTH-1:0] up_rdata_q,  up_rdata_d;
    logic                  dn_valid_q,  dn_valid_d;
    logic                  dn_write_q,  dn_write_d;
    logic [ADDR_WIDTH-1:0] dn_addr_q,   dn_addr_d;
    logic [DATA_WIDTH-1:0] dn_wdata_q,  dn_wdata_d;

    logic [TAG_W-1:0]      w_tag [DEPTH];
    logic                  w_hit;
    logic [PTR_W-1:0]      w_hit_idx;
    logic                  w_req;
    logic                  w_full;
    logic                  w_drain_go;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_tag
            assign w_tag[i] = addr_q[i][ADDR_WIDTH-1:WORD_OFFSET_BITS];
        end
    endgenerate

    bhupura_wb_match #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W),
        .PTR_W (PTR_W)
    ) u_match (
        .i_valid    (valid_q),
        .i_tag      (w_tag),
        .i_head     (head_q),
        .i_tail     (tail_q),
        .i_addr_tag (up.addr[ADDR_WIDTH-1:WORD_OFFSET_BITS]),
        .o_hit      (w_hit),
        .o_idx      (w_hit_idx)
    );

    // up_ready_q masks the request the cache still holds during its ready cycle.
    assign w_req  = (state_q == S_IDLE) && up.valid && !up_ready_q;
    assign w_full = (count_q == c_depth);

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        valid_d    = valid_q;
        addr_d     = addr_q;
        data_d     = data_q;
        up_ready_d = 1'b0;
        up_rdata_d = up_rdata_q;
        dn_valid_d = dn_valid_q;
        dn_write_d = dn_write_q;
        dn_addr_d  = dn_addr_q;
        dn_wdata_d = dn_wdata_q;
        w_drain_go = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_req && up.write) begin
`ifdef BHUPURA_COALESCE_EN
                    if (w_hit) begin
                        data_d[w_hit_idx] = up.wdata;
                        up_ready_d        = 1'b1;
                    end else
`endif
                    if (!w_full) begin
                        addr_d[tail_q]  = up.addr;
                        data_d[tail_q]  = up.wdata;
                        valid_d[tail_q] = 1'b1;
                        tail_d          = (tail_q == c_last_ptr) ? '0 : tail_q + 1'b1;
                        count_d         = count_q + 1'b1;
                        up_ready_d      = 1'b1;
                    end else begin
                        w_drain_go = 1'b1;
                    end
                end else if (w_req) begin
                    if (w_hit) begin
                        up_rdata_d = data_q[w_hit_idx];
                        up_ready_d = 1'b1;
                    end else begin
                        state_d    = S_READ;
                        dn_valid_d = 1'b1;
                        dn_write_d = 1'b0;
                        dn_addr_d  = up.addr;
                    end
                end else if (!up.valid && (count_q != '0)) begin
                    // A held request (even in its ready cycle) keeps the drain off.
                    w_drain_go = 1'b1;
                end
            end

            S_DRAIN: begin
                if (dn.ready) begin
                    valid_d[head_q] = 1'b0;
                    head_d          = (head_q == c_last_ptr) ? '0 : head_q + 1'b1;
                    count_d         = count_q - 1'b1;
                    dn_valid_d      = 1'b0;
                    state_d         = S_IDLE;
                end
            end

            S_READ: begin
                if (dn.ready) begin
                    up_rdata_d = dn.rdata;
                    up_ready_d = 1'b1;
                    dn_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end

            default: begin
                state_d    = S_IDLE;
                dn_valid_d = 1'b0;
            end
        endcase

        if (w_drain_go) begin
            state_d    = S_DRAIN;
            dn_valid_d = 1'b1;
            dn_write_d = 1'b1;
            dn_addr_d  = addr_q[head_q];
            dn_wdata_d = data_q[head_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            up_ready_q <= 1'b0;
            up_rdata_q <= '0;
            dn_valid_q <= 1'b0;
            dn_write_q <= 1'b0;
            dn_addr_q  <= '0;
            dn_wdata_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            up_ready_q <= up_ready_d;
            up_rdata_q <= up_rdata_d;
            dn_valid_q <= dn_valid_d;
            dn_write_q <= dn_write_d;
            dn_addr_q  <= dn_addr_d;
            dn_wdata_q <= dn_wdata_d;
        end
    end

    assign up.ready = up_ready_q;
    assign up.rdata = up_rdata_q;
    assign dn.valid = dn_valid_q;
    assign dn.write = dn_write_q;
    assign dn.addr  = dn_addr_q;
    assign dn.wdata = dn_wdata_q;

    assign wb_count = count_q;
    assign wb_empty = (count_q == '0);
    assign wb_full  = w_full;

endmodule : bhupura_write_buffer

`default_nettype wire

// File: tb/tb_bhupura_write_buffer.sv
//------------------------------------------------------------------------------
// Module  : tb_bhupura_write_buffer
// Brief   : Scoreboard bench for the Bhupura posted write buffer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bhupura_write_buffer;

    localparam int AW    = 32;
    localparam int DW    = 64;
    localparam int CW    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bhupura_write_buffer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) up_if ();
    bhupura_write_buffer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dn_if ();

    logic [CW-1:0] wb_count;
    logic          wb_empty;
    logic          wb_full;

    bhupura_write_buffer u_dut (
        .clk      (clk),
        .rst      (rst),
        .up       (up_if),
        .dn       (dn_if),
        .wb_count (wb_count),
        .wb_empty (wb_empty),
        .wb_full  (wb_full)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
    } dn_log_t;

    ent_t          model_q [$];
    logic [DW-1:0] mem_model [logic [AW-4:0]];
    logic [DW-1:0] exp_rd_q [$];
    dn_log_t       dn_log [$];
    bit            mem_en = 1'b0;
    logic          prev_rdy = 1'b0;
    int            rd_cycles = 0;
    int            n_checks = 0;
    int            n_pass = 0;

    task automatic tb_check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [DW-1:0] backing(input logic [AW-1:0] a);
        if (mem_model.exists(a[AW-1:3])) return mem_model[a[AW-1:3]];
        return {~a, a};
    endfunction

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        for (int i = model_q.size() - 1; i >= 0; i--)
            if (model_q[i].addr[AW-1:3] == a[AW-1:3]) return model_q[i].data;
        return backing(a);
    endfunction

    task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ent_t e;
`ifdef BHUPURA_COALESCE_EN
        foreach (model_q[i]) begin
            if (model_q[i].addr[AW-1:3] == a[AW-1:3]) begin
                model_q[i].data = d;
                return;
            end
        end
`endif
        e.addr = a;
        e.data = d;
        model_q.push_back(e);
    endtask

    // Memory responder: one-cycle ready per observed request while enabled.
    initial begin
        ent_t    e;
        dn_log_t l;
        dn_if.ready = 1'b0;
        dn_if.rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (dn_if.ready) begin
                dn_if.ready = 1'b0;
            end else if (mem_en && dn_if.valid && !rst) begin
                l.wr   = dn_if.write;
                l.addr = dn_if.addr;
                dn_log.push_back(l);
                if (dn_if.write) begin
                    tb_check("drain_pending", model_q.size() != 0, 1);
                    if (model_q.size() != 0) begin
                        e = model_q.pop_front();
                        tb_check("drain_addr", dn_if.addr, e.addr);
                        tb_check("drain_data", dn_if.wdata, e.data);
                        mem_model[e.addr[AW-1:3]] = e.data;
                    end
                end else begin
                    dn_if.rdata = backing(dn_if.addr);
                end
                dn_if.ready = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (up_if.ready) tb_check("up_ready_single", prev_rdy, 0);
            prev_rdy = up_if.ready;
        end
    end

    always @(posedge clk) begin
        if (dn_if.valid && !dn_if.write) rd_cycles <= rd_cycles + 1;
    end

    task automatic do_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input bit hold, output int lat);
        logic [DW-1:0] exp;
        up_if.valid = 1'b1;
        up_if.write = wr;
        up_if.addr  = a;
        up_if.wdata = d;
        if (!wr) exp_rd_q.push_back(model_read(a));
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!up_if.ready && lat < 200);
        tb_check("req_done", up_if.ready, 1);
        if (!wr) begin
            exp = exp_rd_q.pop_front();
            if (up_if.ready) tb_check("up_rdata", up_if.rdata, exp);
        end else if (up_if.ready) begin
            model_write(a, d);
        end
        if (!hold) up_if.valid = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        mem_en = 1'b1;
        n = 0;
        while (!(wb_empty && !dn_if.valid) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        tb_check("drain_all", wb_empty, 1);
        tb_check("model_drained", model_q.size(), 0);
        mem_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int rd0;
        bit saw;
        up_if.valid = 1'b0;
        up_if.write = 1'b0;
        up_if.addr  = '0;
        up_if.wdata = '0;

        repeat (3) @(posedge clk);
        #1;
        tb_check("rst_up_ready", up_if.ready, 0);
        tb_check("rst_up_rdata", up_if.rdata, 0);
        tb_check("rst_dn_valid", dn_if.valid, 0);
        tb_check("rst_dn_write", dn_if.write, 0);
        tb_check("rst_dn_addr", dn_if.addr, 0);
        tb_check("rst_count", wb_count, 0);
        tb_check("rst_empty", wb_empty, 1);
        tb_check("rst_full", wb_full, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back writes with memory stalled, then a held drain.
        do_req(1'b1, 32'h100, 64'h1111, 1'b1, lat);
        tb_check("t1_lat0", lat, 1);
        do_req(1'b1, 32'h108, 64'h2222, 1'b1, lat);
        tb_check("t1_lat1", lat, 2);
        do_req(1'b1, 32'h110, 64'h3333, 1'b0, lat);
        tb_check("t1_lat2", lat, 2);
        tb_check("t1_count", wb_count, 3);
        repeat (2) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            #1;
            tb_check("t1_dn_valid", dn_if.valid, 1);
            tb_check("t1_dn_addr", dn_if.addr, 32'h100);
            tb_check("t1_dn_wdata", dn_if.wdata, 64'h1111);
            @(posedge clk);
        end
        #1;
        wait_empty();

        // Forwarding from a buffered write with memory stalled.
        rd0 = rd_cycles;
        do_req(1'b1, 32'h200, 64'hAAAA, 1'b1, lat);
        do_req(1'b0, 32'h200, 64'h0, 1'b0, lat);
        tb_check("t2_fwd_lat", lat, 2);
        tb_check("t2_no_dn_read", rd_cycles - rd0, 0);
        wait_empty();

        // Same-word writes, then read returns the latest data.
        do_req(1'b1, 32'h300, 64'h1, 1'b1, lat);
        do_req(1'b1, 32'h300, 64'h2, 1'b1, lat);
`ifdef BHUPURA_COALESCE_EN
        tb_check("t3_count", wb_count, 1);
`else
        tb_check("t3_count", wb_count, 2);
`endif
        do_req(1'b0, 32'h300, 64'h0, 1'b0, lat);
        wait_empty();

        // Fill to full, then a 10th write must wait for one drain.
        for (int i = 0; i < 9; i++)
            do_req(1'b1, 32'h1000 + 32'(i * 8), 64'hF000 + 64'(i), 1'b1, lat);
        tb_check("t4_full", wb_full, 1);
        tb_check("t4_count9", wb_count, 9);
        up_if.write = 1'b1;
        up_if.addr  = 32'h900;
        up_if.wdata = 64'h9999;
        saw = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (up_if.ready) saw = 1'b1;
        end
        tb_check("t4_withheld", saw, 0);
        tb_check("t4_drain_held", dn_if.valid && dn_if.write, 1);
        mem_en = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!up_if.ready && lat < 100);
        tb_check("t4_accept", up_if.ready, 1);
        tb_check("t4_count_after", wb_count, 9);
        if (up_if.ready) model_write(32'h900, 64'h9999);
        up_if.valid = 1'b0;
        wait_empty();

        // Read miss overtakes two buffered writes.
        do_req(1'b1, 32'h500, 64'h5050, 1'b1, lat);
        do_req(1'b1, 32'h508, 64'h5858, 1'b1, lat);
        dn_log.delete();
        mem_en = 1'b1;
        do_req(1'b0, 32'h400, 64'h0, 1'b0, lat);
        wait_empty();
        tb_check("t5_log_size", dn_log.size(), 3);
        if (dn_log.size() == 3) begin
            tb_check("t5_first_is_read", dn_log[0].wr, 0);
            tb_check("t5_read_addr", dn_log[0].addr, 32'h400);
            tb_check("t5_drain0", dn_log[1].addr, 32'h500);
            tb_check("t5_drain1", dn_log[2].addr, 32'h508);
        end

        // Reset in the middle of a stalled drain.
        do_req(1'b1, 32'h600, 64'h6666, 1'b1, lat);
        do_req(1'b1, 32'h608, 64'h6868, 1'b0, lat);
        repeat (3) @(posedge clk);
        #1;
        tb_check("t6_in_drain", dn_if.valid, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        tb_check("t6_rst_dn_valid", dn_if.valid, 0);
        tb_check("t6_rst_count", wb_count, 0);
        tb_check("t6_rst_empty", wb_empty, 1);
        rst = 1'b0;
        model_q.delete();
        @(posedge clk);
        #1;
        do_req(1'b1, 32'h700, 64'h7777, 1'b1, lat);
        tb_check("t6_post_lat", lat, 1);
        do_req(1'b0, 32'h700, 64'h0, 1'b1, lat);
        mem_en = 1'b1;
        do_req(1'b0, 32'h600, 64'h0, 1'b0, lat);
        wait_empty();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_bhupura_write_buffer

`default_nettype wire
